mem_if: RTL and testbench
=========================

# mem_if

Memory interface stage directly downstream of the CPU control state machine. Consumes its memory and fetch controls (`mem_cmd`, `addr_sel`, `load_pc`, `reset_pc`, `load_addr`, `load_ir`) and owns the program counter, the data address register, the instruction register, a synchronous-read RAM, and memory-mapped LED/switch I/O. Returns the fetched instruction to the decoder and load data to the datapath write-back mux.

## Interface
- `ADDR_W`, 9: address width.
- `DATA_W`, 16: word width.
- `RAM_WORDS`, 256: RAM depth. Valid RAM addresses are 0..RAM_WORDS-1.
- `LED_ADDR`, 9'h100: write-only LED register address.
- `SW_ADDR`, 9'h140: read-only switch address.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `mem_cmd` in 2: 00 none, 01 read, 11 write, 10 reserved.
- `addr_sel` in 1: 1 selects PC as address, 0 selects the data address register.
- `load_pc` in 1: PC update enable.
- `reset_pc` in 1: with `load_pc`, PC loads 0 instead of incrementing.
- `load_addr` in 1: load the data address register from `write_data[ADDR_W-1:0]`.
- `load_ir` in 1: load `instr` from `read_data`.
- `write_data` in DATA_W: datapath C output; store data and address source.
- `switches` in 8: switch inputs.
- `instr` out DATA_W: instruction register.
- `read_data` out DATA_W: registered read result.
- `rd_valid` out 1: high the cycle after a read is accepted.
- `mem_addr` out ADDR_W: current selected address.
- `pc` out ADDR_W: program counter.
- `leds` out 8: LED register.
- `err` out 1: sticky access-error flag.

## Operation
- `mem_addr` is combinational: `addr_sel ? pc : dar`.
- PC update on each edge:
  - `load_pc & reset_pc`: PC ← 0.
  - `load_pc & ~reset_pc`: PC ← PC+1 mod 2^ADDR_W, so 511 wraps to 0.
  - Otherwise PC holds.
- DAR: when `load_addr`, DAR ← `write_data[8:0]`. Upper bits of `write_data` are ignored.
- Write (`mem_cmd`=11), by `mem_addr`:
  - `mem_addr` < RAM_WORDS: `ram[mem_addr]` ← `write_data`.
  - `mem_addr` == LED_ADDR: `leds` ← `write_data[7:0]`.
  - Any other address: no storage change; `err` ← 1.
- Read (`mem_cmd`=01), by `mem_addr`:
  - RAM address: `read_data` ← `ram[mem_addr]`.
  - `mem_addr` == SW_ADDR: `read_data` ← {8'h00, `switches`}.
  - Any other address: `read_data` ← 16'h0000 and `err` ← 1.
  - In all three cases `rd_valid` ← 1 on the next cycle.
- `read_data` holds its value when no read is issued. `rd_valid` ← 0 on any edge without a read.
- `mem_cmd`=10: no access; `err` ← 1.
- IR: when `load_ir`, `instr` ← current `read_data`, i.e. the value registered by the previous read. A read on the same edge as `load_ir` does not bypass into `instr`.
- Concurrent controls on one edge are independent and all take effect:
  - `load_pc`, `load_addr`, `load_ir` and a memory access.
  - An access uses the pre-edge `pc`/`dar` values.
- `err` is sticky and clears only on reset.

## Timing
- Reset (asynchronous, `reset`=0) forces: `pc`=0, DAR=0, `instr`=0, `read_data`=0, `rd_valid`=0, `leds`=0, `err`=0. `mem_addr` then reads 0.
- RAM contents are not cleared by reset.
- Reset asserted mid-access: the in-flight write is dropped if `reset` is low at the edge. The registers listed above read their reset values immediately.
- Read latency is 1 cycle: a read issued at edge N makes data visible on `read_data` after edge N.
- Fetch sequence:
  - Read with `addr_sel`=1 at edge N.
  - `load_ir` at edge N+1: `instr` = `ram[pc]` after edge N+1.
  - `load_pc` at edge N+2: PC+1.
- Write then read of the same address on consecutive edges returns the new data.
- Write latency: storage or LED updated at the edge on which `mem_cmd`=11 is sampled.

## Test plan
- Reset with `reset`=0 mid-run (`pc`=5, `leds`=8'hAA, `err`=1) → all outputs 0 immediately, before any clock edge.
- DAR=0x010 via `load_addr` (`write_data`=16'h0010); write 16'hBEEF; read next cycle → `read_data`=16'hBEEF, `rd_valid`=1 one cycle after the read, then 0.
- Store 16'hD0A5 at address 0; run `load_pc`+`reset_pc`, then read with `addr_sel`=1, `load_ir`, `load_pc` → `instr`=16'hD0A5, `pc`=1.
- Write `write_data`=16'h1234 to LED_ADDR → `leds`=8'h34, `err`=0; with `switches`=8'h5C, read SW_ADDR → `read_data`=16'h005C.
- Read 0x1FF → `read_data`=0, `err`=1 and stays 1; `mem_cmd`=10 also sets `err`.
- PC=0x1FF with `load_pc` → `pc`=0x000; `load_pc` with `reset_pc` simultaneous with a read at PC → read uses the old PC, `pc`=0 afterwards.

Source files
------------

// File: rtl/mem_if.sv
// Memory interface stage: PC, data address register, IR, sync-read RAM and LED/switch I/O.
// Latency: reads return on read_data one cycle after the read edge; writes land on the issuing edge.
// Backpressure: none; every command is accepted on the edge it is sampled, rd_valid marks read returns.
//
// Ports:
//   clk, reset        - single rising-edge clock, asynchronous active-low reset
//   mem_cmd           - 00 idle, 01 read, 11 write, 10 reserved (flags err)
//   addr_sel          - 1: access at pc, 0: access at the data address register
//   load_pc/reset_pc  - pc increment, or clear when both are set
//   load_addr         - load data address register from write_data[ADDR_W-1:0]
//   load_ir           - capture the current read_data into instr
//   write_data        - store data and address source from the datapath
//   switches          - board switch inputs, visible at SW_ADDR
//   instr, read_data  - instruction register and registered read result
//   rd_valid          - one-cycle pulse following an accepted read
//   mem_addr, pc      - selected access address and program counter
//   leds, err         - LED register and sticky access-error flag

module mem_if #(
  parameter int                ADDR_W    = 9,
  parameter int                DATA_W    = 16,
  parameter int                RAM_WORDS = 256,
  parameter logic [ADDR_W-1:0] LED_ADDR  = 9'h100,
  parameter logic [ADDR_W-1:0] SW_ADDR   = 9'h140
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        mem_cmd,
  input  logic              addr_sel,
  input  logic              load_pc,
  input  logic              reset_pc,
  input  logic              load_addr,
  input  logic              load_ir,
  input  logic [DATA_W-1:0] write_data,
  input  logic [7:0]        switches,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] read_data,
  output logic              rd_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [7:0]        leds,
  output logic              err
);

  localparam int RAM_AW = $clog2(RAM_WORDS);

  localparam logic [1:0] CMD_NONE  = 2'b00;
  localparam logic [1:0] CMD_READ  = 2'b01;
  localparam logic [1:0] CMD_RSVD  = 2'b10;
  localparam logic [1:0] CMD_WRITE = 2'b11;

  // ---------------------------------------------------------------------------
  // Address selection and decode
  // ---------------------------------------------------------------------------
  logic [ADDR_W-1:0] dar;
  logic [RAM_AW-1:0] ram_idx;
  logic              hit_ram;
  logic              hit_led;
  logic              hit_sw;
  logic              cmd_rd;
  logic              cmd_wr;
  logic              cmd_bad;

  assign mem_addr = addr_sel ? pc : dar;
  assign ram_idx  = mem_addr[RAM_AW-1:0];

  // Compare one bit wider so a RAM depth equal to 2^ADDR_W still decodes.
  assign hit_ram  = ({1'b0, mem_addr} < (ADDR_W+1)'(RAM_WORDS));
  assign hit_led  = (mem_addr == LED_ADDR);
  assign hit_sw   = (mem_addr == SW_ADDR);

  assign cmd_rd   = (mem_cmd == CMD_READ);
  assign cmd_wr   = (mem_cmd == CMD_WRITE);
  assign cmd_bad  = (mem_cmd == CMD_RSVD);

  // Any access outside the decoded map, or the reserved command, is an error.
  // LED is write-only and the switches are read-only, so each counts as
  // unmapped for the other direction.
  logic access_err;

  always_comb begin
    access_err = 1'b0;
    case (mem_cmd)
      CMD_READ:  access_err = !(hit_ram || hit_sw);
      CMD_WRITE: access_err = !(hit_ram || hit_led);
      CMD_RSVD:  access_err = 1'b1;
      CMD_NONE:  access_err = 1'b0;
      default:   access_err = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM array: not reset, synchronous read into its own output register.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] ram [RAM_WORDS];
  logic [DATA_W-1:0] ram_q;

  always_ff @(posedge clk) begin
    // The write is dropped when reset is low at the edge.
    if (reset && cmd_wr && hit_ram) begin
      ram[ram_idx] <= write_data;
    end
    if (cmd_rd && hit_ram) begin
      ram_q <= ram[ram_idx];
    end
  end

  // ---------------------------------------------------------------------------
  // Read-result path. read_data muxes between the RAM output register and a
  // small I/O result register; rd_from_ram resets low and io_q resets to zero,
  // so read_data reads zero as soon as reset asserts. Both hold between reads.
  // ---------------------------------------------------------------------------
  logic              rd_from_ram;
  logic [DATA_W-1:0] io_q;
  logic [DATA_W-1:0] io_rd_word;

  // Unmapped reads return zero; only the switch address yields I/O data.
  assign io_rd_word = hit_sw ? DATA_W'(switches) : '0;

  assign read_data  = rd_from_ram ? ram_q : io_q;

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= '0;
      dar         <= '0;
      instr       <= '0;
      rd_from_ram <= 1'b0;
      io_q        <= '0;
      rd_valid    <= 1'b0;
      leds        <= '0;
      err         <= 1'b0;
    end else begin
      // Program counter: clear wins over increment; wraps naturally.
      if (load_pc) begin
        if (reset_pc) begin
          pc <= '0;
        end else begin
          pc <= pc + ADDR_W'(1);
        end
      end

      // Upper write_data bits are not part of the address.
      if (load_addr) begin
        dar <= write_data[ADDR_W-1:0];
      end

      // Captures the pre-edge read_data, so a read on this edge never
      // bypasses straight into instr.
      if (load_ir) begin
        instr <= read_data;
      end

      rd_valid <= cmd_rd;

      if (cmd_rd) begin
        rd_from_ram <= hit_ram;
        if (!hit_ram) begin
          io_q <= io_rd_word;
        end
      end

      if (cmd_wr && hit_led) begin
        leds <= write_data[7:0];
      end

      if (access_err || cmd_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_if.sv
module tb_mem_if;

  logic        clk;
  logic        reset;
  logic [1:0]  mem_cmd;
  logic        addr_sel;
  logic        load_pc;
  logic        reset_pc;
  logic        load_addr;
  logic        load_ir;
  logic [15:0] write_data;
  logic [7:0]  switches;
  logic [15:0] instr;
  logic [15:0] read_data;
  logic        rd_valid;
  logic [8:0]  mem_addr;
  logic [8:0]  pc;
  logic [7:0]  leds;
  logic        err;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  logic [15:0] sb_exp;

  mem_if dut (
    .clk        (clk),
    .reset      (reset),
    .mem_cmd    (mem_cmd),
    .addr_sel   (addr_sel),
    .load_pc    (load_pc),
    .reset_pc   (reset_pc),
    .load_addr  (load_addr),
    .load_ir    (load_ir),
    .write_data (write_data),
    .switches   (switches),
    .instr      (instr),
    .read_data  (read_data),
    .rd_valid   (rd_valid),
    .mem_addr   (mem_addr),
    .pc         (pc),
    .leds       (leds),
    .err        (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Scoreboard: every returned read is matched against the oldest expected word.
  always @(negedge clk) begin
    if (reset && rd_valid) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: rd_valid with read_data=%h, no read outstanding", read_data);
      end else begin
        sb_exp = exp_q.pop_front();
        if (read_data !== sb_exp) begin
          fails++;
          $display("FAIL sb_read_data: got %h want %h", read_data, sb_exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_cmd   = 2'b00;
    addr_sel  = 1'b0;
    load_pc   = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    load_ir   = 1'b0;
  endtask

  task automatic set_dar(input logic [15:0] a);
    load_addr  = 1'b1;
    write_data = a;
    tick();
    load_addr  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    tests++; if (pc !== 9'h000)      begin fails++; $display("FAIL reset_pc: got %h want 000", pc); end
    tests++; if (mem_addr !== 9'h000) begin fails++; $display("FAIL reset_mem_addr: got %h want 000", mem_addr); end
    tests++; if (instr !== 16'h0000)  begin fails++; $display("FAIL reset_instr: got %h want 0000", instr); end
    tests++; if (read_data !== 16'h0000) begin fails++; $display("FAIL reset_read_data: got %h want 0000", read_data); end
    tests++; if (rd_valid !== 1'b0)   begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
    tests++; if (leds !== 8'h00)      begin fails++; $display("FAIL reset_leds: got %h want 00", leds); end
    tests++; if (err !== 1'b0)        begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    #9 reset = 1'b1;
    tick();
  endtask

  task automatic test_dar_rw();
    set_dar(16'h0010);
    tests++; if (mem_addr !== 9'h010) begin fails++; $display("FAIL dar_load: got %h want 010", mem_addr); end
    mem_cmd = 2'b11; write_data = 16'hBEEF;
    tick();
    mem_cmd = 2'b01; exp_q.push_back(16'hBEEF);
    tick();
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL dar_rd_valid_hi: got %b want 1", rd_valid); end
    tests++; if (read_data !== 16'hBEEF) begin fails++; $display("FAIL dar_read: got %h want beef", read_data); end
    mem_cmd = 2'b00;
    tick();
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL dar_rd_valid_lo: got %b want 0", rd_valid); end
    tests++; if (read_data !== 16'hBEEF) begin fails++; $display("FAIL dar_read_hold: got %h want beef", read_data); end
  endtask

  task automatic test_fetch();
    set_dar(16'h0000);
    mem_cmd = 2'b11; write_data = 16'hD0A5;
    tick();
    mem_cmd = 2'b00; load_pc = 1'b1; reset_pc = 1'b1;
    tick();
    tests++; if (pc !== 9'h000) begin fails++; $display("FAIL fetch_pc_clear: got %h want 000", pc); end
    load_pc = 1'b0; reset_pc = 1'b0; addr_sel = 1'b1; mem_cmd = 2'b01;
    exp_q.push_back(16'hD0A5);
    tick();
    mem_cmd = 2'b00; load_ir = 1'b1;
    tick();
    tests++; if (instr !== 16'hD0A5) begin fails++; $display("FAIL fetch_instr: got %h want d0a5", instr); end
    load_ir = 1'b0; load_pc = 1'b1;
    tick();
    tests++; if (pc !== 9'h001) begin fails++; $display("FAIL fetch_pc_inc: got %h want 001", pc); end
    idle();
  endtask

  task automatic test_io();
    set_dar(16'h0100);
    mem_cmd = 2'b11; write_data = 16'h1234;
    tick();
    mem_cmd = 2'b00;
    tests++; if (leds !== 8'h34) begin fails++; $display("FAIL io_leds: got %h want 34", leds); end
    tests++; if (err !== 1'b0)   begin fails++; $display("FAIL io_err_led: got %b want 0", err); end
    set_dar(16'h0140);
    switches = 8'h5C; mem_cmd = 2'b01;
    exp_q.push_back(16'h005C);
    tick();
    mem_cmd = 2'b00;
    tests++; if (read_data !== 16'h005C) begin fails++; $display("FAIL io_switches: got %h want 005c", read_data); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL io_err_sw: got %b want 0", err); end
  endtask

  task automatic test_back_to_back();
    set_dar(16'h0020);
    mem_cmd = 2'b11; write_data = 16'hA1A1;
    tick();
    // Read, load_ir and load_addr together: IR gets the older result,
    // the read uses the old DAR.
    mem_cmd = 2'b01; load_ir = 1'b1; load_addr = 1'b1; write_data = 16'h0021;
    exp_q.push_back(16'hA1A1);
    tick();
    tests++; if (instr !== 16'h005C) begin fails++; $display("FAIL b2b_no_bypass: got %h want 005c", instr); end
    tests++; if (read_data !== 16'hA1A1) begin fails++; $display("FAIL b2b_read_old_dar: got %h want a1a1", read_data); end
    tests++; if (mem_addr !== 9'h021) begin fails++; $display("FAIL b2b_dar_new: got %h want 021", mem_addr); end
    load_ir = 1'b0; load_addr = 1'b0;
    mem_cmd = 2'b11; write_data = 16'h7777;
    tick();
    mem_cmd = 2'b01;
    exp_q.push_back(16'h7777);
    tick();
    exp_q.push_back(16'h7777);
    tick();
    tests++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL b2b_rd_valid: got %b want 1", rd_valid); end
    mem_cmd = 2'b00; load_ir = 1'b1;
    tick();
    load_ir = 1'b0;
    tests++; if (instr !== 16'h7777) begin fails++; $display("FAIL b2b_instr: got %h want 7777", instr); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL b2b_rd_valid_lo: got %b want 0", rd_valid); end
  endtask

  task automatic test_err();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_clean: got %b want 0", err); end
    set_dar(16'hFFFF);
    tests++; if (mem_addr !== 9'h1FF) begin fails++; $display("FAIL err_dar_trunc: got %h want 1ff", mem_addr); end
    mem_cmd = 2'b01;
    exp_q.push_back(16'h0000);
    tick();
    mem_cmd = 2'b00;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_bad_read: got %b want 1", err); end
    repeat (3) tick();
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", err); end
    reset = 1'b0; #1;
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL err_reset_clear: got %b want 0", err); end
    reset = 1'b1;
    mem_cmd = 2'b10;
    tick();
    mem_cmd = 2'b00;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_rsvd_cmd: got %b want 1", err); end
    tests++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL err_rsvd_no_read: got %b want 0", rd_valid); end
    reset = 1'b0; #1; reset = 1'b1;
    set_dar(16'h0140);
    mem_cmd = 2'b11; write_data = 16'h00FF;
    tick();
    mem_cmd = 2'b00;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL err_write_sw: got %b want 1", err); end
    tests++; if (leds !== 8'h00) begin fails++; $display("FAIL err_leds_untouched: got %h want 00", leds); end
  endtask

  task automatic test_reset_midrun();
    load_pc = 1'b1; reset_pc = 1'b1;
    tick();
    reset_pc = 1'b0;
    repeat (5) tick();
    load_pc = 1'b0;
    set_dar(16'h0100);
    mem_cmd = 2'b11; write_data = 16'h00AA;
    tick();
    mem_cmd = 2'b10;
    tick();
    mem_cmd = 2'b00;
    tests++; if (pc !== 9'h005) begin fails++; $display("FAIL mid_pre_pc: got %h want 005", pc); end
    tests++; if (leds !== 8'hAA) begin fails++; $display("FAIL mid_pre_leds: got %h want aa", leds); end
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL mid_pre_err: got %b want 1", err); end
    // Assert reset between edges with a write pending across the next edge.
    mem_cmd = 2'b11; write_data = 16'h9999;
    reset = 1'b0;
    #1;
    tests++; if (pc !== 9'h000)   begin fails++; $display("FAIL mid_pc: got %h want 000", pc); end
    tests++; if (leds !== 8'h00)  begin fails++; $display("FAIL mid_leds: got %h want 00", leds); end
    tests++; if (err !== 1'b0)    begin fails++; $display("FAIL mid_err: got %b want 0", err); end
    tests++; if (read_data !== 16'h0000) begin fails++; $display("FAIL mid_read_data: got %h want 0000", read_data); end
    tests++; if (instr !== 16'h0000) begin fails++; $display("FAIL mid_instr: got %h want 0000", instr); end
    tests++; if (mem_addr !== 9'h000) begin fails++; $display("FAIL mid_mem_addr: got %h want 000", mem_addr); end
    tick();
    reset = 1'b1;
    // Address 0 must still hold the earlier word: the write was dropped and
    // RAM is not cleared by reset.
    mem_cmd = 2'b01;
    exp_q.push_back(16'hD0A5);
    tick();
    mem_cmd = 2'b00;
    tests++; if (read_data !== 16'hD0A5) begin fails++; $display("FAIL mid_write_dropped: got %h want d0a5", read_data); end
  endtask

  task automatic test_pc_wrap();
    load_pc = 1'b1; reset_pc = 1'b1;
    tick();
    reset_pc = 1'b0;
    repeat (511) tick();
    tests++; if (pc !== 9'h1FF) begin fails++; $display("FAIL wrap_pc_max: got %h want 1ff", pc); end
    tick();
    load_pc = 1'b0;
    tests++; if (pc !== 9'h000) begin fails++; $display("FAIL wrap_pc_zero: got %h want 000", pc); end
    set_dar(16'h0003);
    mem_cmd = 2'b11; write_data = 16'hCAFE;
    tick();
    mem_cmd = 2'b00; load_pc = 1'b1;
    repeat (3) tick();
    load_pc = 1'b0;
    tests++; if (pc !== 9'h003) begin fails++; $display("FAIL wrap_pc_three: got %h want 003", pc); end
    // Clear and read at pc on the same edge: the read sees the old pc.
    addr_sel = 1'b1; load_pc = 1'b1; reset_pc = 1'b1; mem_cmd = 2'b01;
    exp_q.push_back(16'hCAFE);
    tick();
    idle();
    tests++; if (pc !== 9'h000) begin fails++; $display("FAIL wrap_clear_pc: got %h want 000", pc); end
    tests++; if (read_data !== 16'hCAFE) begin fails++; $display("FAIL wrap_read_old_pc: got %h want cafe", read_data); end
  endtask

  initial begin
    idle();
    reset      = 1'b1;
    write_data = 16'h0000;
    switches   = 8'h00;
    test_reset();
    test_dar_rw();
    test_fetch();
    test_io();
    test_back_to_back();
    test_err();
    test_reset_midrun();
    test_pc_wrap();
    repeat (2) tick();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL sb_drain: %0d reads outstanding, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
